// File: rtl/data_memory_unit_if.sv
// data_memory_unit_if: pipeline-side load/store bus, debug port and status of the data memory.
interface data_memory_unit_if #(
  parameter int BITS_SIZE      = 32,
  parameter int BITS_EXTENSION = 2,
  parameter int BITS_ERRCNT    = 8
);
  logic                      i_step;
  logic [BITS_SIZE-1:0]      i_alu_address;
  logic [BITS_SIZE-1:0]      i_debug_address;
  logic [BITS_SIZE-1:0]      i_data_register;
  logic                      i_flag_mem_read;
  logic                      i_flag_mem_write;
  logic [BITS_EXTENSION-1:0] i_ctl_data_size_mem;
  logic                      i_unsigned_load;
  logic [BITS_SIZE-1:0]      o_data_read;
  logic [BITS_SIZE-1:0]      o_debug_data;
  logic                      o_busy;
  logic                      o_misaligned;
  logic [BITS_ERRCNT-1:0]    o_error_count;
  modport master (
    output i_step, i_alu_address, i_debug_address, i_data_register, i_flag_mem_read,
           i_flag_mem_write, i_ctl_data_size_mem, i_unsigned_load,
    input  o_data_read, o_debug_data, o_busy, o_misaligned, o_error_count
  );
  modport slave (
    input  i_step, i_alu_address, i_debug_address, i_data_register, i_flag_mem_read,
           i_flag_mem_write, i_ctl_data_size_mem, i_unsigned_load,
    output o_data_read, o_debug_data, o_busy, o_misaligned, o_error_count
  );
endinterface

// File: rtl/data_memory_unit.sv
// data_memory_unit: byte-lane data memory with alignment checking, debug read port and clear-on-reset sequencer.
module data_memory_unit #(
  parameter int BITS_SIZE      = 32,
  parameter int SIZE_MEM_DATA  = 64,
  parameter int BITS_EXTENSION = 2,
  parameter int BITS_ERRCNT    = 8
) (
  input logic i_clk,
  input logic i_reset,
  data_memory_unit_if.slave bus
);
  localparam int AW = $clog2(SIZE_MEM_DATA);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, state_next;
  logic [AW-1:0] clr_ptr;
  logic [BITS_SIZE-1:0] mem [SIZE_MEM_DATA];
  logic [AW-1:0] idx;
  logic [1:0] lane;
  logic sz_w, sz_b, sz_h, active, fault, we, uns;
  logic [BITS_SIZE-1:0] rword, wmask, wdata, din;
  logic [7:0] rbyte;
  logic [15:0] rhalf;
  logic unused_bits;
  assign idx = bus.i_alu_address[AW+1:2];
  assign lane = bus.i_alu_address[1:0];
  assign din = bus.i_data_register;
  assign uns = bus.i_unsigned_load;
  assign unused_bits = ^{bus.i_alu_address[BITS_SIZE-1:AW+2], bus.i_debug_address[BITS_SIZE-1:AW]};
  assign sz_w = bus.i_ctl_data_size_mem == BITS_EXTENSION'(0);
  assign sz_b = bus.i_ctl_data_size_mem == BITS_EXTENSION'(1);
  assign sz_h = bus.i_ctl_data_size_mem == BITS_EXTENSION'(2);
  assign bus.o_busy = state == CLEAR;
  assign active = (bus.i_flag_mem_read | bus.i_flag_mem_write) & bus.i_step & ~bus.o_busy;
  // anything that is not a naturally aligned byte/half/word is a fault, including the reserved code
  assign fault = ~((sz_w & lane == 2'b00) | sz_b | (sz_h & ~lane[0]));
  assign bus.o_misaligned = active & fault;
  assign we = active & bus.i_flag_mem_write & ~fault;
  assign rword = mem[idx];
  assign rbyte = 8'(rword >> {lane, 3'b000});
  assign rhalf = 16'(rword >> {lane[1], 4'b0000});
  assign wmask = sz_b ? BITS_SIZE'(8'hff) << {lane, 3'b000} :
                 sz_h ? BITS_SIZE'(16'hffff) << {lane[1], 4'b0000} : '1;
  assign wdata = sz_b ? BITS_SIZE'(din[7:0]) << {lane, 3'b000} :
                 sz_h ? BITS_SIZE'(din[15:0]) << {lane[1], 4'b0000} : din;
  assign bus.o_data_read = ~(active & bus.i_flag_mem_read & ~fault) ? '0 :
                           sz_b ? {{(BITS_SIZE-8){~uns & rbyte[7]}}, rbyte} :
                           sz_h ? {{(BITS_SIZE-16){~uns & rhalf[15]}}, rhalf} : rword;
  always_comb begin
    state_next = state;
    if (state == CLEAR && clr_ptr == AW'(SIZE_MEM_DATA-1)) state_next = IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_next;
      clr_ptr <= bus.o_busy ? clr_ptr + 1'b1 : clr_ptr;
    end
  end
  always_ff @(posedge i_clk) begin
    if (bus.o_busy) mem[clr_ptr] <= '0;
    else if (we) mem[idx] <= (rword & ~wmask) | (wdata & wmask);
  end
  always_ff @(posedge i_clk) begin
    bus.o_debug_data <= (i_reset | bus.o_busy) ? '0 : mem[bus.i_debug_address[AW-1:0]];
    if (i_reset) bus.o_error_count <= '0;
    else if (bus.o_misaligned & ~&bus.o_error_count) bus.o_error_count <= bus.o_error_count + 1'b1;
  end
endmodule

// File: tb/tb_data_memory_unit.sv
// tb_data_memory_unit: byte-array reference model compared every cycle, plus directed literal checks and random traffic.
module tb_data_memory_unit;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  data_memory_unit_if bus();
  data_memory_unit dut (.i_clk(clk), .i_reset(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  logic [7:0] mb [256];
  int busy_left = 0;
  int err_m = 0;
  logic [31:0] dbg_m = 0;
  bit live = 0;
  logic [31:0] sd;
  logic sm;
  function automatic logic [31:0] mword(input int w);
    return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
  endfunction
  function automatic bit m_active();
    return (bus.i_flag_mem_read | bus.i_flag_mem_write) && bus.i_step && busy_left == 0;
  endfunction
  function automatic bit m_fault();
    case (bus.i_ctl_data_size_mem)
      2'd0: return bus.i_alu_address[1:0] != 2'd0;
      2'd1: return 1'b0;
      2'd2: return bus.i_alu_address[0];
      default: return 1'b1;
    endcase
  endfunction
  function automatic logic [31:0] m_read();
    int b;
    logic [7:0] v;
    logic [15:0] h;
    b = int'(bus.i_alu_address[7:0]);
    if (!(m_active() && bus.i_flag_mem_read && !m_fault())) return 32'h0;
    case (bus.i_ctl_data_size_mem)
      2'd1: begin
        v = mb[b];
        return bus.i_unsigned_load ? {24'h0, v} : {{24{v[7]}}, v};
      end
      2'd2: begin
        h = {mb[b+1], mb[b]};
        return bus.i_unsigned_load ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: return mword(b / 4);
    endcase
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (live) begin
      chk("busy", 32'(bus.o_busy), 32'(busy_left > 0));
      chk("misaligned", 32'(bus.o_misaligned), 32'(m_active() && m_fault()));
      chk("data_read", bus.o_data_read, m_read());
      chk("debug_data", bus.o_debug_data, dbg_m);
      chk("error_count", 32'(bus.o_error_count), 32'(err_m));
    end
  end
  always @(posedge clk) begin : model
    int b;
    logic [31:0] d;
    b = int'(bus.i_alu_address[7:0]);
    d = bus.i_data_register;
    if (rst) begin
      busy_left = 64;
      err_m = 0;
      dbg_m = 0;
      live = 1;
    end else begin
      dbg_m = busy_left > 0 ? 32'h0 : mword(int'(bus.i_debug_address[5:0]));
      if (busy_left > 0) begin
        for (int k = 0; k < 4; k++) mb[4*(64-busy_left)+k] = 8'h0;
        busy_left--;
      end else if (m_active()) begin
        if (m_fault()) err_m = err_m == 255 ? 255 : err_m + 1;
        else if (bus.i_flag_mem_write)
          case (bus.i_ctl_data_size_mem)
            2'd1: mb[b] = d[7:0];
            2'd2: begin
              mb[b] = d[7:0];
              mb[b+1] = d[15:8];
            end
            default: for (int k = 0; k < 4; k++) mb[b+k] = d[8*k +: 8];
          endcase
      end
    end
  end
  task automatic acc(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] d, input logic st);
    bus.i_flag_mem_read = rd;
    bus.i_flag_mem_write = wr;
    bus.i_ctl_data_size_mem = sz;
    bus.i_unsigned_load = uns;
    bus.i_alu_address = a;
    bus.i_data_register = d;
    bus.i_step = st;
    @(negedge clk);
    sd = bus.o_data_read;
    sm = bus.o_misaligned;
    @(posedge clk);
    #1;
    bus.i_flag_mem_read = 0;
    bus.i_flag_mem_write = 0;
    bus.i_step = 1;
  endtask
  task automatic count_busy(output int n);
    n = 0;
    while (bus.o_busy && n < 200) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    int r;
    bus.i_step = 1;
    bus.i_flag_mem_read = 0;
    bus.i_flag_mem_write = 0;
    bus.i_ctl_data_size_mem = 0;
    bus.i_unsigned_load = 0;
    bus.i_alu_address = 0;
    bus.i_debug_address = 0;
    bus.i_data_register = 0;
    @(posedge clk);
    #1;
    rst = 0;
    bus.i_flag_mem_read = 1;
    bus.i_ctl_data_size_mem = 2'd3;
    bus.i_alu_address = 32'h13;
    @(negedge clk);
    chk("post_reset_busy", 32'(bus.o_busy), 32'd1);
    chk("post_reset_misaligned", 32'(bus.o_misaligned), 32'd0);
    chk("post_reset_data_read", bus.o_data_read, 32'd0);
    @(posedge clk);
    #1;
    bus.i_flag_mem_read = 0;
    count_busy(n);
    chk("clear_cycles", 32'(n + 1), 32'd64);
    for (int w = 0; w < 64; w++) begin
      bus.i_debug_address = w;
      @(posedge clk);
      #1;
      chk("cleared_word", bus.o_debug_data, 32'd0);
    end
    bus.i_debug_address = 4;
    acc(0, 1, 2'd0, 0, 32'h10, 32'hDEADBEEF, 1);
    acc(1, 0, 2'd0, 0, 32'h10, 0, 1);
    chk("lw_word", sd, 32'hDEADBEEF);
    chk("debug_word", bus.o_debug_data, 32'hDEADBEEF);
    acc(0, 1, 2'd1, 0, 32'h11, 32'h11, 1);
    acc(1, 0, 2'd0, 0, 32'h10, 0, 1);
    chk("sb_merge", sd, 32'hDEAD11EF);
    acc(1, 0, 2'd1, 0, 32'h13, 0, 1);
    chk("lb_sign", sd, 32'hFFFFFFDE);
    acc(1, 0, 2'd1, 1, 32'h13, 0, 1);
    chk("lbu_zero", sd, 32'h000000DE);
    acc(1, 0, 2'd2, 0, 32'h12, 0, 1);
    chk("lh_sign", sd, 32'hFFFFDEAD);
    acc(0, 1, 2'd0, 0, 32'h12, 32'h12345678, 1);
    chk("sw_misaligned", 32'(sm), 32'd1);
    acc(1, 0, 2'd2, 0, 32'h13, 0, 1);
    chk("lh_misaligned", 32'(sm), 32'd1);
    chk("lh_misaligned_data", sd, 32'd0);
    chk("error_count_two", 32'(bus.o_error_count), 32'd2);
    acc(1, 0, 2'd0, 0, 32'h10, 0, 1);
    chk("unchanged_after_fault", sd, 32'hDEAD11EF);
    bus.i_flag_mem_read = 1;
    bus.i_ctl_data_size_mem = 2'd3;
    repeat (300) @(posedge clk);
    #1;
    bus.i_flag_mem_read = 0;
    chk("error_saturated", 32'(bus.o_error_count), 32'd255);
    acc(0, 1, 2'd0, 0, 32'h20, 32'hAAAA5555, 1);
    acc(1, 1, 2'd0, 0, 32'h20, 32'h12345678, 1);
    chk("rw_old_data", sd, 32'hAAAA5555);
    acc(1, 0, 2'd0, 0, 32'h20, 0, 1);
    chk("rw_new_data", sd, 32'h12345678);
    acc(0, 1, 2'd0, 0, 32'h20, 32'h0, 0);
    acc(1, 0, 2'd0, 0, 32'h20, 0, 1);
    chk("step_gated_store", sd, 32'h12345678);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    n = 0;
    while (bus.o_busy && n < 200) begin
      bus.i_flag_mem_write = n == 40;
      bus.i_ctl_data_size_mem = 2'd0;
      bus.i_alu_address = 32'h20;
      bus.i_data_register = 32'hFFFFFFFF;
      n++;
      @(posedge clk);
      #1;
    end
    bus.i_flag_mem_write = 0;
    chk("restart_clear_cycles", 32'(n), 32'd64);
    acc(1, 0, 2'd0, 0, 32'h20, 0, 1);
    chk("busy_write_dropped", sd, 32'd0);
    repeat (3000) begin
      r = $urandom_range(0, 9);
      bus.i_ctl_data_size_mem = r < 4 ? 2'd0 : r < 7 ? 2'd1 : r < 9 ? 2'd2 : 2'd3;
      bus.i_alu_address = $urandom;
      if ($urandom_range(0, 3) != 0)
        bus.i_alu_address[1:0] = bus.i_ctl_data_size_mem == 2'd2 ? {bus.i_alu_address[1], 1'b0} :
                                 bus.i_ctl_data_size_mem == 2'd0 ? 2'b00 : bus.i_alu_address[1:0];
      bus.i_flag_mem_read = 1'($urandom);
      bus.i_flag_mem_write = 1'($urandom);
      bus.i_unsigned_load = 1'($urandom);
      bus.i_data_register = $urandom;
      bus.i_debug_address = $urandom;
      bus.i_step = $urandom_range(0, 7) != 0;
      rst = $urandom_range(0, 499) == 0;
      @(posedge clk);
      #1;
    end
    rst = 0;
    bus.i_flag_mem_read = 0;
    bus.i_flag_mem_write = 0;
    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_memory_unit.md
DATA_MEMORY_UNIT -- requirements
Module: data_memory_unit

Interface
REQ-001 The block SHALL have parameter BITS_SIZE, default 32, giving the data word width in bits; it SHALL be a multiple of 8 and at least 32.
REQ-002 The block SHALL have parameter SIZE_MEM_DATA, default 64, giving the depth in words; it SHALL be a power of two.
REQ-003 The block SHALL have parameter BITS_EXTENSION, default 2, giving the width of the access-size code.
REQ-004 The block SHALL have parameter BITS_ERRCNT, default 8, giving the width of the error counter.
REQ-005 The block SHALL use one clock, i_clk, input, 1 bit; all state SHALL update on its rising edge.
REQ-006 The block SHALL have reset i_reset, input, 1 bit; it SHALL be synchronous and active-high.
REQ-007 The block SHALL have i_step, input, 1 bit: pipeline advance qualifier for all accesses.
REQ-008 The block SHALL have i_alu_address, input, BITS_SIZE bits: byte address of the access.
REQ-009 The block SHALL have i_debug_address, input, BITS_SIZE bits: word index for the debug read.
REQ-010 The block SHALL have i_data_register, input, BITS_SIZE bits: store data, right-aligned.
REQ-011 The block SHALL have i_flag_mem_read, input, 1 bit: load request.
REQ-012 The block SHALL have i_flag_mem_write, input, 1 bit: store request.
REQ-013 The block SHALL have i_ctl_data_size_mem, input, BITS_EXTENSION bits, with codes 00 = word, 01 = byte, 10 = half, 11 = reserved.
REQ-014 The block SHALL have i_unsigned_load, input, 1 bit: zero-extend loads when 1 (LBU/LHU); sign-extend when 0.
REQ-015 The block SHALL have o_data_read, output, BITS_SIZE bits: extended load data.
REQ-016 The block SHALL have o_debug_data, output, BITS_SIZE bits: registered debug word.
REQ-017 The block SHALL have o_busy, output, 1 bit: high while the reset-clear sequence runs.
REQ-018 The block SHALL have o_misaligned, output, 1 bit: current access is faulty.
REQ-019 The block SHALL have o_error_count, output, BITS_ERRCNT bits: saturating count of faulty accesses.

Function
REQ-020 The word index SHALL be i_alu_address[log2(SIZE_MEM_DATA)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo the depth.
REQ-021 Byte lane addr[1:0] SHALL select bits [8*lane+7 : 8*lane] (little-endian); a half access SHALL use lane addr[1].
REQ-022 An access is "active" when (i_flag_mem_read | i_flag_mem_write) & i_step & ~o_busy.
REQ-023 o_misaligned SHALL be combinational and high when an access is active and any of these holds: half access with addr[0]=1, word access with addr[1:0]≠0, or size code 11.
REQ-024 A faulty access SHALL NOT modify memory, and o_data_read SHALL be 0 during it.
REQ-025 A store SHALL write at the rising edge when active, i_flag_mem_write=1 and not faulty.
REQ-026 A store SHALL modify only the selected byte lanes: byte → 1 lane, half → 2 lanes, word → all lanes; all other bits SHALL be preserved.
REQ-027 The load path SHALL be combinational: when active, i_flag_mem_read=1 and not faulty, o_data_read SHALL be the selected lanes right-aligned and then extended per i_unsigned_load; otherwise o_data_read SHALL be 0.
REQ-028 If a load and a store hit the same cycle, o_data_read SHALL return the pre-write contents, and the write SHALL commit at the edge.
REQ-029 o_debug_data SHALL be registered at every edge as mem[i_debug_address mod SIZE_MEM_DATA] (1-cycle latency, pre-write contents).
REQ-030 While o_busy=1, o_debug_data SHALL be loaded with 0.
REQ-031 o_error_count SHALL increment by 1 at each edge where o_misaligned=1, and SHALL saturate at all-ones.
REQ-032 The clear FSM SHALL have states CLEAR and IDLE.
REQ-033 In CLEAR, the FSM SHALL write 0 to word clr_ptr each cycle, incrementing clr_ptr from 0.
REQ-034 When clr_ptr = SIZE_MEM_DATA-1 has been written, the FSM SHALL go to IDLE; the clear sequence SHALL take exactly SIZE_MEM_DATA cycles.
REQ-035 o_busy SHALL be 1 exactly in CLEAR.
REQ-036 Requests arriving during CLEAR SHALL be ignored (no write, read data 0, no error counted).
REQ-037 With i_step=0, no write, no error count and o_data_read=0 SHALL occur; the debug port SHALL still update.

Reset
REQ-038 While i_reset=1 at an edge, the FSM SHALL enter CLEAR with clr_ptr=0, and o_error_count and o_debug_data SHALL become 0.
REQ-039 A reset asserted mid-CLEAR SHALL restart the clear from word 0.
REQ-040 A reset asserted mid-operation SHALL abort nothing pending, since no access spans cycles.
REQ-041 After reset, o_busy=1, o_misaligned=0 and o_data_read=0 SHALL hold.

Verification
REQ-042 The bench SHALL cover reset then idle: pulse i_reset for 1 cycle → o_busy high for exactly 64 cycles; afterwards the debug read of every word returns 0.
REQ-043 The bench SHALL cover a word store/load: SW 0xDEADBEEF to addr 0x10, then LW addr 0x10 → o_data_read = 0xDEADBEEF; debug addr 4 shows it one cycle later.
REQ-044 The bench SHALL cover byte/half merge with extension: over 0xDEADBEEF at 0x10, SB 0x0000_0011 at 0x11 → word 0xDEAD11EF; LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD.
REQ-045 The bench SHALL cover misalignment: SW at 0x12 and LH at 0x13 → o_misaligned=1 each cycle, memory unchanged, o_error_count=2; forcing 300 faults → count saturates at 255.
REQ-046 The bench SHALL cover a simultaneous read/write and step gating: LW+SW at 0x20 in the same cycle → old data read, new data on the next LW; SW with i_step=0 → no change.
REQ-047 The bench SHALL cover reset mid-clear: assert i_reset at clear cycle 30 → o_busy stays high for 64 further cycles; a write attempted during o_busy is dropped.
